// File: rtl/axis_sel_pkg.sv
// Shared definitions for the packet-aware stream selector scheduler.
package axis_sel_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int BURST_W_DEF = 16;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_BUSY = 1'b1
  } pkt_state_e;

  // Output the active policy would like to use, given its already-evaluated
  // state bits. The reserved mode value behaves like FIXED.
  function automatic logic policy_target(
    input logic [1:0] mode,
    input logic       sel_req,
    input logic       cur_sel,
    input logic       burst_done,
    input logic       fill_done,
    input logic       rearm
  );
    logic t;
    t = sel_req;
    if (mode == MODE_RR) begin
      // After restart the round-robin cycle starts again from output 0.
      t = rearm ? 1'b0 : (burst_done ? ~cur_sel : cur_sel);
    end else if (mode == MODE_FILL) begin
      t = fill_done;
    end
    return t;
  endfunction

endpackage

// File: rtl/axis_pkt_tracker.sv
// Tracks packet framing on an AXI-Stream handshake and reports the points
// where a downstream route may legally change.
module axis_pkt_tracker
  import axis_sel_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic in_packet,
  output logic last,
  output logic boundary_ok
);

  pkt_state_e state_q;
  pkt_state_e state_d;
  logic       beat;

  assign beat = tvalid & tready;
  assign last = beat & tlast;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    if (!resetn) state_q <= PKT_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: a multi-beat packet opens BUSY, its TLAST closes it.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    case (state_q)
      PKT_IDLE: if (beat && !tlast) state_d = PKT_BUSY;
      PKT_BUSY: if (last)           state_d = PKT_IDLE;
      default:                      state_d = PKT_IDLE;
    endcase
  end

  assign in_packet = (state_q == PKT_BUSY);

  // A waiting beat in IDLE is already presented to the current sink, so the
  // route may only move when nothing is offered or a packet just completed.
  assign boundary_ok = last | ((state_q == PKT_IDLE) & ~tvalid);

endmodule

// File: rtl/axis_sel_sched.sv
// Drives the select of a two-way AXI-Stream output selector, moving it only
// at packet boundaries, and counts completed packets per output.
module axis_sel_sched
  import axis_sel_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         mode,
  input  logic               sel_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               restart,
  input  logic               rx_tvalid,
  input  logic               rx_tready,
  input  logic               rx_tlast,
  output logic               output_sel,
  output logic               in_packet,
  output logic               switch_pending,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
);

  logic               last;
  logic               boundary_ok;

  logic               sel_q, sel_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic [BURST_W-1:0] burst_q, burst_b, burst_d;
  logic               fill_q, fill_d;
  logic               rearm_q, rearm_b, rearm_d;
  logic [BURST_W-1:0] len_eff;
  logic               target_now;
  logic               target_d;

  axis_pkt_tracker u_tracker (
    .clk         (clk),
    .resetn      (resetn),
    .tvalid      (rx_tvalid),
    .tready      (rx_tready),
    .tlast       (rx_tlast),
    .in_packet   (in_packet),
    .last        (last),
    .boundary_ok (boundary_ok)
  );

  assign len_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;

  // Policy bookkeeping: the select loaded at a TLAST edge already accounts
  // for the packet completing on that edge, so bursts switch bubble-free.
  always_comb begin
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    burst_b  = burst_q;
    fill_d   = fill_q;
    rearm_b  = rearm_q | restart;
    if (restart) begin
      // Clearing wins over a coincident packet completion.
      cnt0_d  = '0;
      cnt1_d  = '0;
      burst_b = '0;
      fill_d  = 1'b0;
    end else if (last) begin
      if (sel_q) cnt1_d = cnt1_q + CNT_W'(1);
      else       cnt0_d = cnt0_q + CNT_W'(1);
      if (mode == MODE_RR && burst_q != '1) burst_b = burst_q + BURST_W'(1);
      if (mode == MODE_FILL && cnt0_d >= CNT_W'(len_eff)) fill_d = 1'b1;
    end
    target_d = policy_target(mode, sel_req, sel_q, burst_b >= len_eff,
                             fill_d, rearm_b);
    sel_d    = boundary_ok ? target_d : sel_q;
    burst_d  = (sel_d != sel_q) ? '0 : burst_b;
    rearm_d  = rearm_b & sel_d;
  end

  // Policy and select registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      burst_q <= '0;
      fill_q  <= 1'b0;
      rearm_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      burst_q <= burst_d;
      fill_q  <= fill_d;
      rearm_q <= rearm_d;
    end
  end

  assign target_now = policy_target(mode, sel_req, sel_q, burst_q >= len_eff,
                                    fill_q, rearm_q);

  assign output_sel     = sel_q;
  assign switch_pending = (target_now != sel_q);
  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;

endmodule

// File: tb/tb_axis_sel_sched.sv
// Self-checking bench for axis_sel_sched: directed table, packet sequences
// and a randomized run against a packet-level reference model.
module tb_axis_sel_sched;
  import axis_sel_pkg::*;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic               clk;
  logic               resetn;
  logic [1:0]         mode;
  logic               sel_req;
  logic [BURST_W-1:0] burst_len;
  logic               restart;
  logic               rx_tvalid;
  logic               rx_tready;
  logic               rx_tlast;
  logic               output_sel;
  logic               in_packet;
  logic               switch_pending;
  logic [CNT_W-1:0]   pkt_cnt0;
  logic [CNT_W-1:0]   pkt_cnt1;

  axis_sel_sched #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mode           (mode),
    .sel_req        (sel_req),
    .burst_len      (burst_len),
    .restart        (restart),
    .rx_tvalid      (rx_tvalid),
    .rx_tready      (rx_tready),
    .rx_tlast       (rx_tlast),
    .output_sel     (output_sel),
    .in_packet      (in_packet),
    .switch_pending (switch_pending),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic got_out[$];

  typedef struct {
    logic        v, r, l, sreq;
    logic        e_sel, e_inp, e_pend;
    logic [31:0] e_c0, e_c1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive the handshake, then sample just after the edge.
  task automatic cyc(input logic v, input logic r, input logic l);
    rx_tvalid = v;
    rx_tready = r;
    rx_tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    restart = 1'b0;
  endtask

  // Back-to-back packet of len beats; every beat must use the first beat's output.
  task automatic send_pkt(input int len, input string tag);
    logic first_out;
    first_out = output_sel;
    got_out.push_back(first_out);
    for (int b = 0; b < len; b++) begin
      if (b > 0) check({tag, "_integrity"}, output_sel, first_out);
      cyc(1'b1, 1'b1, b == len - 1);
    end
  endtask

  // ---------------- reference model (packet-level rules) ----------------
  bit          m_in, m_sel, m_fill, m_rearm;
  int          m_run;
  logic [31:0] m_cnt [2];

  function automatic bit want(input int md, input bit sreq, input int bl, input int run,
                              input bit fill, input bit rearm, input bit cur);
    int eff;
    eff = (bl == 0) ? 1 : bl;
    if (md == 1) return rearm ? 1'b0 : ((run >= eff) ? !cur : cur);
    if (md == 2) return fill;
    return sreq;
  endfunction

  task automatic model_step(input bit v, input bit r, input bit l, input bit rst);
    bit beat, lst, prev, bound;
    int eff;
    beat = v & r;
    lst  = beat & l;
    prev = m_sel;
    eff  = (burst_len == 0) ? 1 : int'(burst_len);
    if (rst) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_run = 0; m_fill = 0; m_rearm = 1;
    end else if (lst) begin
      m_cnt[m_sel] = m_cnt[m_sel] + 1;
      if (mode == MODE_RR) m_run++;
      if (mode == MODE_FILL && m_cnt[0] >= eff) m_fill = 1;
    end
    bound = lst || (!m_in && !v);
    if (bound) m_sel = want(int'(mode), sel_req, int'(burst_len), m_run, m_fill, m_rearm, m_sel);
    if (m_sel != prev) m_run = 0;
    if (!m_sel) m_rearm = 0;
    if (beat) m_in = !l;
  endtask

  initial begin
    vec_t tbl [6];
    logic rr_exp [6];
    logic fl_exp [5];
    logic sb_exp [6];
    bit   hold_v, hold_l, cur_v, cur_l, cur_r, cur_rst, pkt_out, exp_pend;

    rr_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    fl_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sb_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // FIXED: sel_req rises on the 3rd beat of a 5-beat packet.
    tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    tbl[4] = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
    tbl[5] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};

    resetn = 1'b0; mode = MODE_FIXED; sel_req = 1'b0; burst_len = 16'd1;
    restart = 1'b0; rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tlast = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("rst_sel", output_sel, 0);
    check("rst_inpkt", in_packet, 0);
    check("rst_pend", switch_pending, 0);
    check("rst_cnt0", pkt_cnt0, 0);
    check("rst_cnt1", pkt_cnt1, 0);
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      sel_req = tbl[i].sreq;
      cyc(tbl[i].v, tbl[i].r, tbl[i].l);
      check($sformatf("fix%0d_sel", i), output_sel, tbl[i].e_sel);
      check($sformatf("fix%0d_inpkt", i), in_packet, tbl[i].e_inp);
      check($sformatf("fix%0d_pend", i), switch_pending, tbl[i].e_pend);
      check($sformatf("fix%0d_cnt0", i), pkt_cnt0, tbl[i].e_c0);
      check($sformatf("fix%0d_cnt1", i), pkt_cnt1, tbl[i].e_c1);
    end

    // ROUND_ROBIN, bursts of 2, six back-to-back 4-beat packets.
    mode = MODE_RR; burst_len = 16'd2;
    pulse_restart();
    check("rr_start_sel", output_sel, 0);
    got_out.delete();
    for (int p = 0; p < 6; p++) send_pkt(4, "rr");
    for (int p = 0; p < 6; p++) check($sformatf("rr_pkt%0d_out", p), got_out[p], rr_exp[p]);
    check("rr_cnt0", pkt_cnt0, 4);
    check("rr_cnt1", pkt_cnt1, 2);
    cyc(1'b0, 1'b1, 1'b0);

    // FILL, 3 packets to output 0 then stay on 1.
    mode = MODE_FILL; burst_len = 16'd3;
    pulse_restart();
    check("fill_start_sel", output_sel, 0);
    got_out.delete();
    for (int p = 0; p < 5; p++) send_pkt(2, "fill");
    for (int p = 0; p < 5; p++) check($sformatf("fill_pkt%0d_out", p), got_out[p], fl_exp[p]);
    check("fill_cnt0", pkt_cnt0, 3);
    check("fill_cnt1", pkt_cnt1, 2);
    check("fill_pend_end", switch_pending, 0);
    cyc(1'b0, 1'b1, 1'b0);

    // IDLE with a stalled beat: select must hold while sel_req disagrees.
    mode = MODE_FIXED; sel_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    sel_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("stall%0d_sel", i), output_sel, 1);
      check($sformatf("stall%0d_pend", i), switch_pending, 1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("stall_release_sel", output_sel, 0);
    check("stall_release_pend", switch_pending, 0);

    // ROUND_ROBIN with burst_len=0: alternate on every single-beat packet.
    mode = MODE_RR; burst_len = 16'd0;
    pulse_restart();
    got_out.delete();
    for (int p = 0; p < 6; p++) begin
      send_pkt(1, "sb");
      check($sformatf("sb%0d_inpkt", p), in_packet, 0);
    end
    for (int p = 0; p < 6; p++) check($sformatf("sb_pkt%0d_out", p), got_out[p], sb_exp[p]);
    check("sb_cnt0", pkt_cnt0, 3);
    check("sb_cnt1", pkt_cnt1, 3);
    cyc(1'b0, 1'b1, 1'b0);

    // restart mid-packet on output 1: counters clear, select waits for TLAST.
    mode = MODE_FILL; burst_len = 16'd1;
    pulse_restart();
    send_pkt(2, "mid");
    check("mid_on1_sel", output_sel, 1);
    cyc(1'b1, 1'b1, 1'b0);
    restart = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    restart = 1'b0;
    check("mid_cnt0_clr", pkt_cnt0, 0);
    check("mid_cnt1_clr", pkt_cnt1, 0);
    check("mid_sel_held", output_sel, 1);
    check("mid_inpkt", in_packet, 1);
    check("mid_pend", switch_pending, 1);
    cyc(1'b1, 1'b1, 1'b1);
    check("mid_sel_after", output_sel, 0);
    check("mid_cnt1_after", pkt_cnt1, 1);
    check("mid_inpkt_after", in_packet, 0);

    // restart coincident with TLAST drops that packet's count.
    mode = MODE_FIXED; sel_req = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    restart = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    restart = 1'b0;
    check("rstlast_cnt0", pkt_cnt0, 0);
    check("rstlast_cnt1", pkt_cnt1, 0);

    // Randomized run against the reference model.
    resetn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    m_in = 0; m_sel = 0; m_fill = 0; m_rearm = 0; m_run = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    hold_v = 0; hold_l = 0; pkt_out = 0;
    mode = MODE_FIXED; burst_len = 16'd1; sel_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        mode      = 2'($urandom_range(0, 3));
        burst_len = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) sel_req = ~sel_req;
      if (hold_v) begin
        cur_v = 1; cur_l = hold_l;
      end else begin
        cur_v = ($urandom_range(0, 2) != 0);
        cur_l = ($urandom_range(0, 3) == 0);
      end
      cur_r   = ($urandom_range(0, 3) != 0);
      cur_rst = ($urandom_range(0, 63) == 0);
      hold_v  = cur_v && !cur_r;
      hold_l  = cur_l;
      if (cur_v && cur_r) begin
        if (!m_in) pkt_out = output_sel;
        else check("rnd_integrity", output_sel, pkt_out);
      end
      model_step(cur_v, cur_r, cur_l, cur_rst);
      restart = cur_rst;
      cyc(cur_v, cur_r, cur_l);
      exp_pend = (want(int'(mode), sel_req, int'(burst_len), m_run, m_fill, m_rearm, m_sel) != m_sel);
      check("rnd_sel", output_sel, m_sel);
      check("rnd_inpkt", in_packet, m_in);
      check("rnd_pend", switch_pending, exp_pend);
      check("rnd_cnt0", pkt_cnt0, m_cnt[0]);
      check("rnd_cnt1", pkt_cnt1, m_cnt[1]);
      restart = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
